// File: rtl/module_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply and
// restoring divide over XLEN cycles, with single-cycle handling of divide special cases.
module module_muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic            flush_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] result_o,
   output logic            done_o,
   output logic            busy_o,
   output logic            stall_o
);

   // Handshake: a request is taken when start_i is high and flush_i low while the unit
   // is IDLE or FIN; stall_o holds the pipeline from the request cycle until the result is
   // valid, and drops in FIN so EX/MEM captures result_o on the following edge.

   localparam int CW = $clog2(XLEN) + 1;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     count_q;
   logic [2:0]        op_q;
   logic              neg_q;
   logic [XLEN-1:0]   opnd_q;
   logic [XLEN-1:0]   result_q;
   logic [2*XLEN-1:0] acc_q;

   logic              accept, is_div, signed_a, signed_b, a_neg, b_neg, sign_in;
   logic              div_zero, ovf, special, last_iter;
   logic [XLEN-1:0]   a_abs, b_abs, special_res;

   logic [XLEN:0]     mul_sum, div_wide, div_diff;
   logic              div_ok;
   logic [XLEN-1:0]   div_rem, div_sel, div_fix, mul_sel, final_res;
   logic [2*XLEN-1:0] mul_next, div_next, acc_step, prod_fix;

   // Operand conditioning and special-case detection on the request inputs
   always_comb begin
      accept   = start_i && !flush_i && (state_q == IDLE || state_q == FIN);
      is_div   = op_i[2];
      signed_a = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                 (op_i == OP_DIV) || (op_i == OP_REM);
      signed_b = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
      a_neg    = signed_a && a_i[XLEN-1];
      b_neg    = signed_b && b_i[XLEN-1];
      a_abs    = a_neg ? -a_i : a_i;
      b_abs    = b_neg ? -b_i : b_i;
      case (op_i)
         OP_MUL, OP_MULH, OP_DIV: sign_in = a_neg ^ b_neg;
         OP_MULHSU, OP_REM:       sign_in = a_neg;
         default:                 sign_in = 1'b0;
      endcase
      div_zero = is_div && (b_i == '0);
      ovf      = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                 (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
      special  = div_zero || ovf;
      // op_i[1] separates remainder (REM/REMU) from quotient (DIV/DIVU)
      if (div_zero)
         special_res = op_i[1] ? a_i : '1;
      else
         special_res = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end

   // One iteration of multiply (shift-add, right shift) or divide (restoring, left shift)
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next  = {mul_sum, acc_q[XLEN-1:1]};
      div_wide  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff  = div_wide - {1'b0, opnd_q};
      div_ok    = !div_diff[XLEN];
      div_rem   = div_ok ? div_diff[XLEN-1:0] : div_wide[XLEN-1:0];
      div_next  = {div_rem, acc_q[XLEN-2:0], div_ok};
      acc_step  = op_q[2] ? div_next : mul_next;
      // Sign is applied to the full product so the high half is correct
      prod_fix  = neg_q ? -acc_step : acc_step;
      mul_sel   = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      div_sel   = op_q[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
      div_fix   = neg_q ? -div_sel : div_sel;
      final_res = op_q[2] ? div_fix : mul_sel;
      last_iter = (state_q == CALC) && (count_q == CW'(XLEN-1));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, FIN: begin
            if (accept)
               state_d = special ? FIN : CALC;
            else if (state_q == FIN)
               state_d = IDLE;
         end
         CALC: begin
            if (flush_i)
               state_d = IDLE;
            else if (last_iter)
               state_d = FIN;
         end
         default: state_d = IDLE;
      endcase
      done_o   = (state_q == FIN);
      busy_o   = (state_q != IDLE);
      stall_o  = (start_i && (state_q == IDLE) && !flush_i) || (state_q == CALC);
      result_o = result_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         count_q  <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q    <= op_i;
            neg_q   <= sign_in;
            count_q <= '0;
            opnd_q  <= is_div ? b_abs : a_abs;
            acc_q   <= {{XLEN{1'b0}}, (is_div ? a_abs : b_abs)};
            if (special)
               result_q <= special_res;
         end else if (state_q == CALC && !flush_i) begin
            acc_q   <= acc_step;
            count_q <= count_q + 1'b1;
            if (last_iter)
               result_q <= final_res;
         end
      end
   end

endmodule

// File: tb/tb_module_muldiv_unit.sv
// Directed bench for module_muldiv_unit: hand-computed vectors for multiply, divide,
// special cases, back-to-back issue, ignored start, flush and asynchronous reset.
module tb_module_muldiv_unit;

   localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
   localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
   localparam int NORMAL_CYC  = 33;  // negedges after accept edge until done: cycle after edge 32
   localparam int SPECIAL_CYC = 1;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        start_i, flush_i;
   logic [2:0]  op_i;
   logic [31:0] a_i, b_i;
   logic [31:0] result_o;
   logic        done_o, busy_o, stall_o;

   int vectors = 0;
   int miscompares = 0;

   module_muldiv_unit #(.XLEN(32)) dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .start_i  (start_i),
      .flush_i  (flush_i),
      .op_i     (op_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .result_o (result_o),
      .done_o   (done_o),
      .busy_o   (busy_o),
      .stall_o  (stall_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issues one operation at the current negedge and waits (bounded) for done_o.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_cyc,
                         input bit from_idle);
      int cyc;
      int stall_low;
      op_i = op; a_i = a; b_i = b; start_i = 1'b1;
      #1;
      if (from_idle) check({tag, "_stall_req"}, {31'd0, stall_o}, 32'd1);
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      a_i = $urandom; b_i = $urandom; op_i = 3'($urandom_range(0, 7));
      cyc = 0; stall_low = 0;
      do begin
         @(negedge clk_i);
         cyc++;
         if (!done_o && !stall_o) stall_low++;
      end while (!done_o && cyc < 200);
      check({tag, "_cycles"}, cyc, exp_cyc);
      check({tag, "_result"}, result_o, exp);
      if (exp_cyc > 1) check({tag, "_stall_calc_low"}, stall_low, 0);
      check({tag, "_stall_fin"}, {31'd0, stall_o}, 32'd0);
   endtask

   task automatic expect_idle(input string tag);
      @(negedge clk_i);
      check({tag, "_done_drop"}, {31'd0, done_o}, 32'd0);
      check({tag, "_busy_idle"}, {31'd0, busy_o}, 32'd0);
   endtask

   initial begin
      int done_seen;
      rst_ni = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = MUL; a_i = '0; b_i = '0;
      @(negedge clk_i);
      check("rst_result", result_o, 32'd0);
      check("rst_done", {31'd0, done_o}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_stall", {31'd0, stall_o}, 32'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      run_op("mul_7_m3", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, NORMAL_CYC, 1'b1);
      run_op("mulh_min", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, NORMAL_CYC, 1'b0);
      run_op("mulhu_max", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, NORMAL_CYC, 1'b0);
      run_op("mulhsu_m1", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NORMAL_CYC, 1'b0);
      expect_idle("mul_grp");

      run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NORMAL_CYC, 1'b1);
      run_op("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NORMAL_CYC, 1'b0);
      run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, NORMAL_CYC, 1'b0);
      run_op("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, NORMAL_CYC, 1'b0);
      expect_idle("div_grp");

      run_op("div_by0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, SPECIAL_CYC, 1'b1);
      expect_idle("div_by0");
      run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_CYC, 1'b1);
      run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPECIAL_CYC, 1'b0);
      run_op("remu_by0", REMU, 32'd5, 32'd0, 32'd5, SPECIAL_CYC, 1'b0);
      expect_idle("spec_grp");

      // MUL 3*5 interrupted: start at CALC cycle 5 ignored, flush at CALC cycle 10
      op_i = MUL; a_i = 32'd3; b_i = 32'd5; start_i = 1'b1;
      @(posedge clk_i);
      #1 start_i = 1'b0;
      repeat (5) @(negedge clk_i);
      start_i = 1'b1; op_i = DIVU; a_i = 32'd9; b_i = 32'd3;
      #1 check("ign_stall", {31'd0, stall_o}, 32'd1);
      @(negedge clk_i);
      start_i = 1'b0;
      check("ign_busy", {31'd0, busy_o}, 32'd1);
      check("ign_done", {31'd0, done_o}, 32'd0);
      repeat (4) @(negedge clk_i);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      check("flush_busy", {31'd0, busy_o}, 32'd0);
      check("flush_done", {31'd0, done_o}, 32'd0);
      check("flush_stall", {31'd0, stall_o}, 32'd0);
      check("flush_result", result_o, 32'd5);
      done_seen = 0;
      repeat (40) begin
         @(negedge clk_i);
         if (done_o) done_seen++;
      end
      check("flush_no_done", done_seen, 0);
      run_op("divu_9_3", DIVU, 32'd9, 32'd3, 32'd3, NORMAL_CYC, 1'b1);
      expect_idle("divu_9_3");

      // Asynchronous reset in the middle of CALC
      op_i = MUL; a_i = 32'd7; b_i = 32'd3; start_i = 1'b1;
      @(posedge clk_i);
      #1 start_i = 1'b0;
      repeat (5) @(negedge clk_i);
      check("pre_rst_busy", {31'd0, busy_o}, 32'd1);
      #2 rst_ni = 1'b0;
      #1;
      check("arst_result", result_o, 32'd0);
      check("arst_done", {31'd0, done_o}, 32'd0);
      check("arst_busy", {31'd0, busy_o}, 32'd0);
      check("arst_stall", {31'd0, stall_o}, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (3) @(negedge clk_i);
      check("post_rst_busy", {31'd0, busy_o}, 32'd0);
      check("post_rst_done", {31'd0, done_o}, 32'd0);

      // Flush and start together in IDLE: no accept
      start_i = 1'b1; flush_i = 1'b1; op_i = DIVU; a_i = 32'd9; b_i = 32'd3;
      #1 check("fs_stall", {31'd0, stall_o}, 32'd0);
      @(negedge clk_i);
      start_i = 1'b0; flush_i = 1'b0;
      check("fs_busy", {31'd0, busy_o}, 32'd0);
      @(negedge clk_i);
      check("fs_done", {31'd0, done_o}, 32'd0);
      check("fs_result", result_o, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
